// File: rtl/hamming_secded_codec_pkg.sv
// Shared definitions for the SECDED Hamming codec.
//   codec_mode_t   : per-transaction operation (encode / decode)
//   codec_status_t : decode outcome (no error, single corrected, double detected)
//   calc_par_w()   : number of Hamming parity bits needed for a data width
package hamming_secded_codec_pkg;

    typedef enum logic {
        ENC = 1'b0,
        DEC = 1'b1
    } codec_mode_t;

    typedef enum logic [1:0] {
        OK  = 2'd0,
        SEC = 2'd1,
        DED = 2'd2
    } codec_status_t;

    // Smallest r with 2^r >= data_w + r + 1 (overall parity bit not included).
    function automatic int calc_par_w(input int data_w);
        int r;
        r = 0;
        for (int k = 1; k < 8; k++) begin
            if (r == 0 && (1 << k) >= data_w + k + 1) begin
                r = k;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational Hamming position-mask evaluator.
//   code   : CODE_W-bit word (bit 0 = overall parity, 1..CODE_W-1 = Hamming positions)
//   result : {syndrome, overall parity}; syndrome is the XOR of the indices of
//            all set bits at positions 1..CODE_W-1, parity is the XOR of all bits.
module hamming_syndrome
    import hamming_secded_codec_pkg::*;
#(
    parameter  int DATA_W = 11,
    localparam int PAR_W  = calc_par_w(DATA_W),
    localparam int CODE_W = DATA_W + PAR_W + 1
) (
    input  logic [CODE_W-1:0] code,
    output logic [PAR_W:0]    result
);

    logic [PAR_W-1:0] syn;

    always_comb begin
        syn = '0;
        for (int i = 1; i < CODE_W; i++) begin
            if (code[i]) begin
                syn = syn ^ PAR_W'(i);
            end
        end
        result = {syn, ^code};
    end

endmodule

// File: rtl/hamming_secded_codec.sv
// Two-stage pipelined SECDED Hamming encoder/decoder with valid/ready flow
// control and saturating error counters.
//   CLK, Reset            : clock, asynchronous active-high reset
//   in_valid/in_ready     : input handshake; mode, data_in, code_in captured on accept
//   out_valid/out_ready   : output handshake; code_out, data_out, status, err_pos
//   sec_count, ded_count  : saturating counts of delivered SEC / DED results
//   cnt_clear             : synchronous clear of both counters (wins over increment)
module hamming_secded_codec
    import hamming_secded_codec_pkg::*;
#(
    parameter  int DATA_W = 11,
    parameter  int CNT_W  = 8,
    localparam int PAR_W  = calc_par_w(DATA_W),
    localparam int CODE_W = DATA_W + PAR_W + 1,
    localparam int POS_W  = $clog2(CODE_W)
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  codec_mode_t       mode,
    input  logic [DATA_W-1:0] data_in,
    input  logic [CODE_W-1:0] code_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] code_out,
    output logic [DATA_W-1:0] data_out,
    output codec_status_t     status,
    output logic [POS_W-1:0]  err_pos,
    output logic [CNT_W-1:0]  sec_count,
    output logic [CNT_W-1:0]  ded_count,
    input  logic              cnt_clear
);

    // Data bits occupy the non-power-of-two positions in ascending order.
    function automatic logic [CODE_W-1:0] place_data(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] cw;
        int j;
        cw = '0;
        j  = 0;
        for (int i = 1; i < CODE_W; i++) begin
            if ((i & (i - 1)) != 0) begin
                cw[i] = d[j];
                j++;
            end
        end
        return cw;
    endfunction

    function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] cw);
        logic [DATA_W-1:0] d;
        int j;
        d = '0;
        j = 0;
        for (int i = 1; i < CODE_W; i++) begin
            if ((i & (i - 1)) != 0) begin
                d[j] = cw[i];
                j++;
            end
        end
        return d;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic              vld_p1;
    codec_mode_t       mode_p1;
    logic [DATA_W-1:0] data_p1;
    logic [CODE_W-1:0] code_p1;

    logic              s1_advance;
    logic [CODE_W-1:0] placed;
    logic [CODE_W-1:0] syn_in;
    logic [PAR_W:0]    syn_res;
    logic [PAR_W-1:0]  syn;
    logic              par;
    logic [CODE_W-1:0] enc_cw;
    logic [CODE_W-1:0] res_code;
    logic [DATA_W-1:0] res_data;
    codec_status_t     res_status;
    logic [POS_W-1:0]  res_pos;

    assign s1_advance = !out_valid || out_ready;
    assign in_ready   = !vld_p1 || s1_advance;

    // ---- stage 1: capture transaction ----
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            vld_p1 <= 1'b0;
        end else if (in_ready) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge CLK) begin
        if (in_ready && in_valid) begin
            mode_p1 <= mode;
            data_p1 <= data_in;
            code_p1 <= code_in;
        end
    end

    // One syndrome unit serves both modes: with parity positions left at zero,
    // the syndrome of the placed data is exactly the parity-bit vector.
    assign placed = place_data(data_p1);
    assign syn_in = (mode_p1 == DEC) ? code_p1 : placed;

    hamming_syndrome #(.DATA_W(DATA_W)) u_syndrome (
        .code   (syn_in),
        .result (syn_res)
    );

    assign syn = syn_res[PAR_W:1];
    assign par = syn_res[0];

    always_comb begin
        enc_cw = placed;
        for (int k = 0; k < PAR_W; k++) begin
            enc_cw[1 << k] = syn[k];
        end
        enc_cw[0] = ^enc_cw[CODE_W-1:1];

        res_code   = code_p1;
        res_status = OK;
        res_pos    = '0;
        if (mode_p1 == ENC) begin
            res_code = enc_cw;
        end else if (par) begin
            if (syn == '0) begin
                res_code[0] = ~code_p1[0];
                res_status  = SEC;
            end else if (int'(syn) < CODE_W) begin
                res_code   = code_p1 ^ (CODE_W'(1) << syn);
                res_status = SEC;
                res_pos    = POS_W'(syn);
            end else begin
                // Odd parity but the syndrome points past the word: multi-bit error.
                res_status = DED;
            end
        end else if (syn != '0) begin
            res_status = DED;
        end
        res_data = (mode_p1 == ENC) ? data_p1 : extract_data(res_code);
    end

    // ---- stage 2: registered result ----
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            out_valid <= 1'b0;
            code_out  <= '0;
            data_out  <= '0;
            status    <= OK;
            err_pos   <= '0;
        end else if (s1_advance) begin
            out_valid <= vld_p1;
            if (vld_p1) begin
                code_out <= res_code;
                data_out <= res_data;
                status   <= res_status;
                err_pos  <= res_pos;
            end
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            sec_count <= '0;
            ded_count <= '0;
        end else if (cnt_clear) begin
            sec_count <= '0;
            ded_count <= '0;
        end else if (out_valid && out_ready) begin
            if (status == SEC) sec_count <= sat_inc(sec_count);
            if (status == DED) ded_count <= sat_inc(ded_count);
        end
    end

endmodule
